// File: rtl/jacaranda_pkg.sv
// Shared constants for the jacaranda-8 Wishbone loader: register offsets,
// CTRL/STATUS bit positions and FSM state encodings.
package jacaranda_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_ADDR   = 5'h04;
    localparam logic [4:0] OFF_DATA   = 5'h08;
    localparam logic [4:0] OFF_STATUS = 5'h0C;
    localparam logic [4:0] OFF_CSUM   = 5'h10;

    localparam int CTRL_CPU_RESET_BIT = 0;
    localparam int CTRL_AUTO_INC_BIT  = 1;
    localparam int STATUS_ERR_BIT     = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR      = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_ACK     = 2'd3;

endpackage

// File: rtl/jacaranda_wb_loader_if.sv
// Wishbone classic slave-side bus bundle for the jacaranda loader.
interface jacaranda_wb_loader_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/jacaranda_wb_decode.sv
// Combinational window-hit and register-offset decode for the 32-byte
// loader window at BASE_ADDR.
module jacaranda_wb_decode #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        stb,
    input  logic        cyc,
    input  logic [31:0] adr,
    output logic        req,
    output logic [4:0]  off
);

    logic hit;
    logic unused_adr_bits;

    assign hit = (adr[31:5] == BASE_ADDR[31:5]);
    assign req = stb & cyc & hit;
    // Registers are word-aligned; byte lanes within a word alias.
    assign off = {adr[4:2], 2'b00};

    assign unused_adr_bits = ^adr[1:0];

endmodule

// File: rtl/jacaranda_wb_loader.sv
// Wishbone classic slave that loads, reads back and controls the jacaranda-8
// core's instruction memory. Define JACARANDA_WB_LOADER_CSUM_EN for the CSUM register.
module jacaranda_wb_loader
    import jacaranda_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IM_AW     = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    jacaranda_wb_loader_if.slave wbs,
    output logic [IM_AW-1:0]     im_addr,
    output logic [7:0]           im_w_data,
    output logic                 im_w_en,
    input  logic [7:0]           im_r_data,
    output logic                 cpu_reset
);

    logic       req;
    logic [4:0] off;

    jacaranda_wb_decode #(
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .stb (wbs.wbs_stb_i),
        .cyc (wbs.wbs_cyc_i),
        .adr (wbs.wbs_adr_i),
        .req (req),
        .off (off)
    );

    logic [1:0]       state_q,     state_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             auto_inc_q,  auto_inc_d;
    logic [IM_AW-1:0] ptr_q,       ptr_d;
    logic [7:0]       wr_count_q,  wr_count_d;
    logic             err_q,       err_d;
    logic             txn_ok_q,    txn_ok_d;
    logic             ack_q,       ack_d;
    logic [31:0]      dat_o_q,     dat_o_d;
    logic             im_w_en_q,   im_w_en_d;
    logic [7:0]       im_w_data_q, im_w_data_d;
`ifdef JACARANDA_WB_LOADER_CSUM_EN
    logic [7:0]       csum_q,      csum_d;
`endif

    logic [31:0] reg_rdata;
    logic        wr_en;
    logic        unused_bus_bits;

    assign wr_en           = wbs.wbs_we_i & wbs.wbs_sel_i[0];
    assign unused_bus_bits = ^{wbs.wbs_sel_i[3:1], wbs.wbs_dat_i};

    always_comb begin
        reg_rdata = '0;
        case (off)
            OFF_CTRL: begin
                reg_rdata[CTRL_CPU_RESET_BIT] = cpu_reset_q;
                reg_rdata[CTRL_AUTO_INC_BIT]  = auto_inc_q;
            end
            OFF_ADDR: reg_rdata[IM_AW-1:0] = ptr_q;
            OFF_STATUS: begin
                reg_rdata[7:0]            = wr_count_q;
                reg_rdata[STATUS_ERR_BIT] = err_q;
            end
`ifdef JACARANDA_WB_LOADER_CSUM_EN
            OFF_CSUM: reg_rdata[7:0] = csum_q;
`endif
            default: reg_rdata = '0;
        endcase
    end

    // NOTE: every _d gets a default up front so no path through the case
    // statement leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        cpu_reset_d = cpu_reset_q;
        auto_inc_d  = auto_inc_q;
        ptr_d       = ptr_q;
        wr_count_d  = wr_count_q;
        err_d       = err_q;
        txn_ok_d    = txn_ok_q;
        im_w_data_d = im_w_data_q;
        im_w_en_d   = 1'b0;
        ack_d       = 1'b0;
        dat_o_d     = '0;
`ifdef JACARANDA_WB_LOADER_CSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (off == OFF_DATA && !(wbs.wbs_we_i && !wbs.wbs_sel_i[0])) begin
                        // Memory is only reachable while the core is parked.
                        txn_ok_d = cpu_reset_q;
                        if (!cpu_reset_q) begin
                            err_d = 1'b1;
                        end
                        if (wbs.wbs_we_i) begin
                            state_d   = ST_WR;
                            im_w_en_d = cpu_reset_q;
                            if (cpu_reset_q) begin
                                im_w_data_d = wbs.wbs_dat_i[7:0];
                            end
                        end else begin
                            state_d = ST_RD_WAIT;
                        end
                    end else begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        if (!wbs.wbs_we_i) begin
                            dat_o_d = reg_rdata;
                        end else if (wr_en) begin
                            case (off)
                                OFF_CTRL: begin
                                    cpu_reset_d = wbs.wbs_dat_i[CTRL_CPU_RESET_BIT];
                                    auto_inc_d  = wbs.wbs_dat_i[CTRL_AUTO_INC_BIT];
                                end
                                OFF_ADDR: ptr_d = wbs.wbs_dat_i[IM_AW-1:0];
                                OFF_STATUS: begin
                                    if (wbs.wbs_dat_i[STATUS_ERR_BIT]) begin
                                        err_d = 1'b0;
                                    end
                                end
`ifdef JACARANDA_WB_LOADER_CSUM_EN
                                OFF_CSUM: csum_d = '0;
`endif
                                default: ;
                            endcase
                        end
                    end
                end
            end

            ST_WR: begin
                state_d = ST_ACK;
                ack_d   = 1'b1;
                if (txn_ok_q) begin
                    wr_count_d = wr_count_q + 8'd1;
`ifdef JACARANDA_WB_LOADER_CSUM_EN
                    csum_d     = csum_q + im_w_data_q;
`endif
                    if (auto_inc_q) begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end

            ST_RD_WAIT: begin
                state_d = ST_ACK;
                ack_d   = 1'b1;
                if (txn_ok_q) begin
                    dat_o_d = {24'd0, im_r_data};
                    if (auto_inc_q) begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cpu_reset_q <= 1'b1;
            auto_inc_q  <= 1'b1;
            ptr_q       <= '0;
            wr_count_q  <= '0;
            err_q       <= 1'b0;
            txn_ok_q    <= 1'b0;
            ack_q       <= 1'b0;
            dat_o_q     <= '0;
            im_w_en_q   <= 1'b0;
            im_w_data_q <= '0;
`ifdef JACARANDA_WB_LOADER_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cpu_reset_q <= cpu_reset_d;
            auto_inc_q  <= auto_inc_d;
            ptr_q       <= ptr_d;
            wr_count_q  <= wr_count_d;
            err_q       <= err_d;
            txn_ok_q    <= txn_ok_d;
            ack_q       <= ack_d;
            dat_o_q     <= dat_o_d;
            im_w_en_q   <= im_w_en_d;
            im_w_data_q <= im_w_data_d;
`ifdef JACARANDA_WB_LOADER_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_o_q;
    assign im_addr       = ptr_q;
    assign im_w_data     = im_w_data_q;
    assign im_w_en       = im_w_en_q;
    assign cpu_reset     = cpu_reset_q;

endmodule

// File: tb/tb_jacaranda_wb_loader.sv
// Directed self-checking bench for jacaranda_wb_loader with a registered
// 256-byte instruction memory model on the im_* port.
module tb_jacaranda_wb_loader;
    import jacaranda_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] im_addr;
    logic [7:0] im_w_data;
    logic       im_w_en;
    logic [7:0] im_r_data = 8'h00;
    logic       cpu_reset;

    logic [7:0] mem [256] = '{default: 8'h00};
    int         wen_pulses = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    jacaranda_wb_loader_if bus ();

    jacaranda_wb_loader #(
        .BASE_ADDR (BASE),
        .IM_AW     (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs       (bus.slave),
        .im_addr   (im_addr),
        .im_w_data (im_w_data),
        .im_w_en   (im_w_en),
        .im_r_data (im_r_data),
        .cpu_reset (cpu_reset)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (im_w_en) begin
            mem[im_addr] <= im_w_data;
            wen_pulses   <= wen_pulses + 1;
        end
        im_r_data <= mem[im_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rdata, output int lat);
        @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        lat   = 0;
        rdata = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) begin
                lat   = i;
                rdata = bus.wbs_dat_o;
                break;
            end
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [4:0] off, input logic [31:0] dat, input int exp_lat);
        logic [31:0] rd_unused;
        int lat;
        xfer(1'b1, BASE + 32'(off), dat, 4'b1111, rd_unused, lat);
        check({tag, " ack latency"}, lat, exp_lat);
    endtask

    task automatic rd(input string tag, input logic [4:0] off, input logic [31:0] exp, input int exp_lat);
        logic [31:0] rdata;
        int lat;
        xfer(1'b0, BASE + 32'(off), 32'h0, 4'b1111, rdata, lat);
        check({tag, " ack latency"}, lat, exp_lat);
        check({tag, " data"}, rdata, exp);
    endtask

    initial begin
        logic [31:0] rdata;
        int lat;
        int acks;
        int wen_snap;

        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;

        // Reset state while reset is held.
        #12;
        check("rst cpu_reset", cpu_reset, 1);
        check("rst ack", bus.wbs_ack_o, 0);
        check("rst dat_o", bus.wbs_dat_o, 0);
        check("rst im_w_en", im_w_en, 0);
        check("rst im_addr", im_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        rd("ctrl after reset", OFF_CTRL, 32'h3, 1);
        rd("status after reset", OFF_STATUS, 32'h0, 1);

        // Burst load at 0x10 with auto-increment.
        wr("addr 0x10", OFF_ADDR, 32'h10, 1);
        wr("data a5", OFF_DATA, 32'hA5, 2);
        wr("data 5a", OFF_DATA, 32'h5A, 2);
        wr("data ff", OFF_DATA, 32'hFF, 2);
        check("mem[10]", mem[8'h10], 8'hA5);
        check("mem[11]", mem[8'h11], 8'h5A);
        check("mem[12]", mem[8'h12], 8'hFF);
        check("burst wen pulses", wen_pulses, 3);
        check("burst im_addr", im_addr, 8'h13);
        rd("ptr after burst", OFF_ADDR, 32'h13, 1);
        rd("status after burst", OFF_STATUS, 32'h3, 1);
        rd("readback 0x13 empty", OFF_DATA, 32'h0, 2);
        rd("ptr after read", OFF_ADDR, 32'h14, 1);

        // Pointer wrap on write and on read.
        wr("addr ff", OFF_ADDR, 32'hFF, 1);
        wr("data 42", OFF_DATA, 32'h42, 2);
        rd("ptr wrap write", OFF_ADDR, 32'h0, 1);
        check("mem[ff]", mem[8'hFF], 8'h42);
        wr("addr ff again", OFF_ADDR, 32'hFF, 1);
        rd("readback ff", OFF_DATA, 32'h42, 2);
        rd("ptr wrap read", OFF_ADDR, 32'h0, 1);
        rd("status wr_count 4", OFF_STATUS, 32'h4, 1);

        // Run-mode guard: DATA accesses are refused and flag err.
        wr("ctrl run", OFF_CTRL, 32'h2, 1);
        check("run cpu_reset", cpu_reset, 0);
        wen_snap = wen_pulses;
        wr("run data write", OFF_DATA, 32'h11, 2);
        check("run no wen", wen_pulses, wen_snap);
        check("run mem[00]", mem[8'h00], 8'h00);
        rd("run status err", OFF_STATUS, 32'h104, 1);
        rd("run ptr kept", OFF_ADDR, 32'h0, 1);
        rd("run data read", OFF_DATA, 32'h0, 2);
        wr("status w1c", OFF_STATUS, 32'h100, 1);
        rd("status err cleared", OFF_STATUS, 32'h4, 1);
        rd("ctrl run readback", OFF_CTRL, 32'h2, 1);
        wr("ctrl park", OFF_CTRL, 32'h3, 1);
        rd("park ptr kept", OFF_ADDR, 32'h0, 1);
        rd("park wr_count kept", OFF_STATUS, 32'h4, 1);

        // Out-of-window strobe is never acknowledged.
        @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = BASE + 32'h40;
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.wbs_ack_o) acks++;
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        check("out of window acks", acks, 0);

        // Writes with sel[0]=0 are acked but change nothing.
        xfer(1'b1, BASE + 32'(OFF_ADDR), 32'h55, 4'b0000, rdata, lat);
        check("sel0 addr acked", 32'(lat != 0), 1);
        rd("sel0 ptr unchanged", OFF_ADDR, 32'h0, 1);
        wen_snap = wen_pulses;
        xfer(1'b1, BASE + 32'(OFF_DATA), 32'h66, 4'b0000, rdata, lat);
        check("sel0 data acked", 32'(lat != 0), 1);
        check("sel0 data no wen", wen_pulses, wen_snap);
        rd("sel0 wr_count", OFF_STATUS, 32'h4, 1);

        rd("reserved 0x14", 5'h14, 32'h0, 1);
        wr("reserved 0x1c write", 5'h1C, 32'hFFFF_FFFF, 1);
        rd("reserved no effect ctrl", OFF_CTRL, 32'h3, 1);

        // Auto-increment disabled holds the pointer.
        wr("ctrl no inc", OFF_CTRL, 32'h1, 1);
        wr("addr 0x20", OFF_ADDR, 32'h20, 1);
        wr("data 77", OFF_DATA, 32'h77, 2);
        rd("no inc ptr", OFF_ADDR, 32'h20, 1);
        check("mem[20]", mem[8'h20], 8'h77);
        rd("no inc readback", OFF_DATA, 32'h77, 2);
        rd("no inc ptr after read", OFF_ADDR, 32'h20, 1);
        rd("wr_count 5", OFF_STATUS, 32'h5, 1);

        wr("ctrl park inc", OFF_CTRL, 32'h3, 1);
`ifdef JACARANDA_WB_LOADER_CSUM_EN
        wr("csum clear", OFF_CSUM, 32'h0, 1);
        rd("csum cleared", OFF_CSUM, 32'h0, 1);
        wr("csum data 80", OFF_DATA, 32'h80, 2);
        wr("csum data 90", OFF_DATA, 32'h90, 2);
        rd("csum 80+90", OFF_CSUM, 32'h10, 1);
`else
        wr("csum write ignored", OFF_CSUM, 32'hAB, 1);
        rd("csum reads 0", OFF_CSUM, 32'h0, 1);
`endif

        // Async reset landing in RD_WAIT: no ack, outputs back to reset.
        wr("pre-rst addr", OFF_ADDR, 32'h33, 1);
        wr("pre-rst data", OFF_DATA, 32'h9C, 2);
        check("pre-rst im_w_data", im_w_data, 8'h9C);
        wr("pre-rst ctrl run", OFF_CTRL, 32'h2, 1);
        @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = BASE + 32'(OFF_DATA);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid rst ack", bus.wbs_ack_o, 0);
        check("mid rst dat_o", bus.wbs_dat_o, 0);
        check("mid rst cpu_reset", cpu_reset, 1);
        check("mid rst im_w_en", im_w_en, 0);
        check("mid rst im_w_data", im_w_data, 0);
        check("mid rst im_addr", im_addr, 0);
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.wbs_ack_o) acks++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.wbs_ack_o) acks++;
        end
        check("mid rst no ack", acks, 0);
        rd("post rst ctrl", OFF_CTRL, 32'h3, 1);
        rd("post rst status", OFF_STATUS, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
